// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RISC-V core:
//   - ALU opcode encoding (alu_op_e), including the compare ops that set Flag
//   - fetch FSM state encoding (fetch_state_e)
//   - NOP_INSTR (addi x0, x0, 0) and the default reset PC
//   - pc_incr(): sequential next-PC helper
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_BEQ  = 4'd10,
        ALU_BNE  = 4'd11,
        ALU_BLT  = 4'd12,
        ALU_BGE  = 4'd13,
        ALU_BLTU = 4'd14,
        ALU_BGEU = 4'd15
    } alu_op_e;

    typedef enum logic [2:0] {
        FS_IDLE = 3'd0,
        FS_REQ  = 3'd1,
        FS_HOLD = 3'd2,
        FS_DROP = 3'd3,
        FS_TRAP = 3'd4
    } fetch_state_e;

    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_target_riscv.sv
// -----------------------------------------------------------------------------
// pc_target_riscv
// Combinational redirect decision and target computation for the fetch stage.
// Optional feature macro: PC_MISALIGN_TRAP_EN (adds o_misalign; target keeps
// bit 1 so a misaligned jump can be trapped instead of silently aligned).
//
// Ports:
//   i_valid    execute presents a resolved control-flow instruction
//   i_branch, i_jal, i_jalr  instruction class (one-hot or none)
//   i_flag     ALU branch condition
//   i_pc, i_imm, i_rs1       execute PC, sign-extended immediate, rs1 value
//   o_taken    redirect this cycle
//   o_target   redirect target
//   o_misalign target bit 1 set (only with PC_MISALIGN_TRAP_EN)
// -----------------------------------------------------------------------------
module pc_target_riscv (
    input  logic        i_valid,
    input  logic        i_branch,
    input  logic        i_jal,
    input  logic        i_jalr,
    input  logic        i_flag,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_rs1,
    output logic        o_taken,
`ifdef PC_MISALIGN_TRAP_EN
    output logic        o_misalign,
`endif
    output logic [31:0] o_target
);

    // With the trap enabled only bit 0 is cleared (JALR rule); bit 1 survives
    // so it can be flagged. Without it the target is forced word-aligned.
`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [31:0] TARGET_MASK = 32'hFFFF_FFFE;
`else
    localparam logic [31:0] TARGET_MASK = 32'hFFFF_FFFC;
`endif

    logic [31:0] w_base;
    logic [31:0] w_sum;

    always_comb begin
        w_base   = i_jalr ? i_rs1 : i_pc;
        w_sum    = w_base + i_imm;          // 32-bit modulo, wrap is legal
        o_taken  = i_valid && (i_jal || i_jalr || (i_branch && i_flag));
        o_target = w_sum & TARGET_MASK;
`ifdef PC_MISALIGN_TRAP_EN
        o_misalign = w_sum[1];
`endif
    end

endmodule

// File: rtl/fetch_pc_riscv.sv
// -----------------------------------------------------------------------------
// fetch_pc_riscv
// Instruction-fetch / program-counter stage. Holds the PC, fetches over a
// req/ack instruction-memory port, presents instructions to decode through a
// valid/ready handshake, and redirects on taken branches / JAL / JALR.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect target
// enters a sticky TRAP state and raises trap_o).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req_o, imem_addr_o    fetch request / word address (held until ack)
//   imem_ack_i, imem_rdata_i   memory acknowledge / instruction data
//   if_valid_o, if_instr_o, if_pc_o  instruction to decode
//   id_ready_i                 decode accepts this cycle
//   ex_valid_i, ex_branch_i, ex_jal_i, ex_jalr_i, ex_flag_i,
//   ex_pc_i, ex_imm_i, ex_rs1_i  resolved control-flow info from execute
//   trap_o                     misaligned-target trap (macro only)
// -----------------------------------------------------------------------------
module fetch_pc_riscv
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    input  logic        id_ready_i,
    input  logic        ex_valid_i,
    input  logic        ex_branch_i,
    input  logic        ex_jal_i,
    input  logic        ex_jalr_i,
    input  logic        ex_flag_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_imm_i,
`ifdef PC_MISALIGN_TRAP_EN
    input  logic [31:0] ex_rs1_i,
    output logic        trap_o
`else
    input  logic [31:0] ex_rs1_i
`endif
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;       // next fetch address; drives imem_addr_o
    logic [31:0]  r_target;   // redirect target saved while a request drains
    logic         r_req;
    logic         r_valid;
    logic [31:0]  r_instr;
    logic [31:0]  r_if_pc;

    logic         w_taken;
    logic [31:0]  w_target;
    logic [31:0]  w_drop_tgt;

`ifdef PC_MISALIGN_TRAP_EN
    logic         r_trap;
    logic         r_trap_pend;  // saved target in DROP is misaligned
    logic         w_misalign;
    logic         w_drop_bad;
`endif

    pc_target_riscv u_target (
        .i_valid    (ex_valid_i),
        .i_branch   (ex_branch_i),
        .i_jal      (ex_jal_i),
        .i_jalr     (ex_jalr_i),
        .i_flag     (ex_flag_i),
        .i_pc       (ex_pc_i),
        .i_imm      (ex_imm_i),
        .i_rs1      (ex_rs1_i),
        .o_taken    (w_taken),
`ifdef PC_MISALIGN_TRAP_EN
        .o_misalign (w_misalign),
`endif
        .o_target   (w_target)
    );

    // In DROP the newest redirect wins, including one arriving with the ack.
    assign w_drop_tgt = w_taken ? w_target : r_target;
`ifdef PC_MISALIGN_TRAP_EN
    assign w_drop_bad = w_taken ? w_misalign : r_trap_pend;
    assign trap_o     = r_trap;
`endif

    assign imem_req_o  = r_req;
    assign imem_addr_o = r_pc;
    assign if_valid_o  = r_valid;
    assign if_instr_o  = r_instr;
    assign if_pc_o     = r_if_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FS_IDLE;
            r_pc        <= RESET_PC;
            r_target    <= RESET_PC;
            r_req       <= 1'b0;
            r_valid     <= 1'b0;
            r_instr     <= NOP_INSTR;
            r_if_pc     <= RESET_PC;
`ifdef PC_MISALIGN_TRAP_EN
            r_trap      <= 1'b0;
            r_trap_pend <= 1'b0;
`endif
        end else begin
            case (r_state)
                FS_IDLE: begin
                    r_pc    <= RESET_PC;
                    r_req   <= 1'b1;
                    r_state <= FS_REQ;
                end

                FS_REQ: begin
                    if (w_taken) begin
                        if (imem_ack_i) begin
                            // Data returned is stale: drop it and refetch at
                            // the target; the request line stays high.
`ifdef PC_MISALIGN_TRAP_EN
                            if (w_misalign) begin
                                r_req   <= 1'b0;
                                r_trap  <= 1'b1;
                                r_state <= FS_TRAP;
                            end else begin
                                r_pc <= w_target;
                            end
`else
                            r_pc <= w_target;
`endif
                        end else begin
                            // Request cannot be withdrawn: drain it first.
                            r_target <= w_target;
`ifdef PC_MISALIGN_TRAP_EN
                            r_trap_pend <= w_misalign;
`endif
                            r_state  <= FS_DROP;
                        end
                    end else if (imem_ack_i) begin
                        r_instr <= imem_rdata_i;
                        r_if_pc <= r_pc;
                        r_pc    <= pc_incr(r_pc);
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= FS_HOLD;
                    end
                end

                FS_HOLD: begin
                    // Redirect beats a same-cycle id_ready_i: held instruction
                    // is on the wrong path and is not handed over.
                    if (w_taken) begin
                        r_valid <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
                        if (w_misalign) begin
                            r_trap  <= 1'b1;
                            r_state <= FS_TRAP;
                        end else begin
                            r_pc    <= w_target;
                            r_req   <= 1'b1;
                            r_state <= FS_REQ;
                        end
`else
                        r_pc    <= w_target;
                        r_req   <= 1'b1;
                        r_state <= FS_REQ;
`endif
                    end else if (id_ready_i) begin
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= FS_REQ;
                    end
                end

                FS_DROP: begin
                    if (imem_ack_i) begin
`ifdef PC_MISALIGN_TRAP_EN
                        if (w_drop_bad) begin
                            r_req   <= 1'b0;
                            r_trap  <= 1'b1;
                            r_state <= FS_TRAP;
                        end else begin
                            r_pc    <= w_drop_tgt;
                            r_state <= FS_REQ;
                        end
`else
                        r_pc    <= w_drop_tgt;
                        r_state <= FS_REQ;
`endif
                    end else if (w_taken) begin
                        r_target <= w_target;
`ifdef PC_MISALIGN_TRAP_EN
                        r_trap_pend <= w_misalign;
`endif
                    end
                end

`ifdef PC_MISALIGN_TRAP_EN
                FS_TRAP: begin
                    r_state <= FS_TRAP;   // sticky until reset
                end
`endif

                default: begin
                    r_state <= FS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_riscv.sv
module tb_fetch_pc_riscv;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_branch = 1'b0;
    logic        ex_jal = 1'b0;
    logic        ex_jalr = 1'b0;
    logic        ex_flag = 1'b0;
    logic [31:0] ex_pc = 32'h0;
    logic [31:0] ex_imm = 32'h0;
    logic [31:0] ex_rs1 = 32'h0;
`ifdef PC_MISALIGN_TRAP_EN
    logic        trap;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] q_req[$];   // expected request addresses, in order
    logic [31:0] q_acc[$];   // expected PCs accepted by decode, in order

    int ack_delay = 0;

    fetch_pc_riscv #(.RESET_PC(RPC)) dut (
`ifdef PC_MISALIGN_TRAP_EN
        .trap_o       (trap),
`endif
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_ack_i   (imem_ack),
        .imem_rdata_i (imem_rdata),
        .if_valid_o   (if_valid),
        .if_instr_o   (if_instr),
        .if_pc_o      (if_pc),
        .id_ready_i   (id_ready),
        .ex_valid_i   (ex_valid),
        .ex_branch_i  (ex_branch),
        .ex_jal_i     (ex_jal),
        .ex_jalr_i    (ex_jalr),
        .ex_flag_i    (ex_flag),
        .ex_pc_i      (ex_pc),
        .ex_imm_i     (ex_imm),
        .ex_rs1_i     (ex_rs1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic br, input logic jal, input logic jalr, input logic flag,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                         input logic rdy);
        ex_valid = 1'b1; ex_branch = br; ex_jal = jal; ex_jalr = jalr; ex_flag = flag;
        ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; id_ready = rdy;
        cyc();
        ex_valid = 1'b0; ex_branch = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0; ex_flag = 1'b0;
        id_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   {31'h0, imem_req}, 32'h0);
        chk({tag, "_addr"},  imem_addr, RPC);
        chk({tag, "_valid"}, {31'h0, if_valid}, 32'h0);
        chk({tag, "_instr"}, if_instr, 32'h0000_0013);
        chk({tag, "_pc"},    if_pc, RPC);
    endtask

    // Instruction memory: decides ack for the current cycle after outputs settle.
    int  mem_cnt  = 0;
    int  mem_dly  = 0;
    bit  mem_busy = 1'b0;
    always @(posedge clk) begin
        #2;
        if (!rst_n || !imem_req) begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            mem_busy   = 1'b0;
        end else begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_cnt  = 0;
                mem_dly  = ack_delay;
            end
            if (mem_cnt == mem_dly) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                mem_busy   = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
                mem_cnt++;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request or hands
    // an instruction to decode.
    bit          m_pend = 1'b0;
    logic [31:0] m_addr = 32'h0;
    bit          m_held = 1'b0;
    logic [31:0] m_hpc  = 32'h0;
    logic [31:0] m_hins = 32'h0;
    always @(negedge clk) begin
        logic redir;
        logic acc;
        logic [31:0] e;
        if (!rst_n) begin
            m_pend = 1'b0;
            m_held = 1'b0;
        end else begin
            if (imem_req) begin
                if (m_pend) begin
                    chk("req_addr_stable", imem_addr, m_addr);
                end else if (q_req.size() == 0) begin
                    chk("unexpected_req", imem_addr, 32'hFFFF_FFFF);
                end else begin
                    e = q_req.pop_front();
                    chk("req_addr", imem_addr, e);
                end
                m_pend = !imem_ack;
                m_addr = imem_addr;
            end else begin
                if (m_pend) chk("req_withdrawn", {31'h0, imem_req}, 32'h1);
                m_pend = 1'b0;
            end

            redir = ex_valid && (ex_jal || ex_jalr || (ex_branch && ex_flag));
            acc   = if_valid && id_ready && !redir;
            if (if_valid && m_held) begin
                chk("hold_pc_stable", if_pc, m_hpc);
                chk("hold_instr_stable", if_instr, m_hins);
            end
            if (acc) begin
                if (q_acc.size() == 0) begin
                    chk("unexpected_accept", if_pc, 32'hFFFF_FFFF);
                end else begin
                    e = q_acc.pop_front();
                    chk("accept_pc", if_pc, e);
                    chk("accept_instr", if_instr, mem_word(e));
                end
            end
            m_held = if_valid;
            m_hpc  = if_pc;
            m_hins = if_instr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hp;

        // Reset values and sequential fetch with zero-wait memory
        repeat (3) cyc();
        chk_reset_vals("reset");
        q_req.push_back(32'h100); q_req.push_back(32'h104); q_req.push_back(32'h108);
        q_acc.push_back(32'h100); q_acc.push_back(32'h104);
        id_ready = 1'b1;
        rst_n = 1'b1;
        chk("first_req_c0", {31'h0, imem_req}, 32'h0);
        cyc();
        chk("first_req_c1", {31'h0, imem_req}, 32'h1);
        chk("first_addr_c1", imem_addr, 32'h100);
        cyc();
        chk("zero_wait_valid", {31'h0, if_valid}, 32'h1);
        cyc(); cyc(); cyc();
        id_ready = 1'b0;
        cyc();

        // Decode stall for 5 cycles in HOLD
        repeat (5) cyc();
        chk("stall_no_req", {31'h0, imem_req}, 32'h0);
        chk("stall_pc", if_pc, 32'h108);
        q_acc.push_back(32'h108); q_req.push_back(32'h10C);
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
        cyc(); cyc();
        chk("after_stall_pc", if_pc, 32'h10C);

        // BEQ taken while in HOLD
        q_req.push_back(32'h240);
        pulse(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h40, 32'h0, 1'b0);
        chk("beq_valid_drop", {31'h0, if_valid}, 32'h0);
        cyc(); cyc();

        // BEQ not taken: no redirect, nothing changes
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h40, 32'h0, 1'b0);
        chk("bne_valid_kept", {31'h0, if_valid}, 32'h1);
        chk("bne_pc_kept", if_pc, 32'h240);
        cyc(); cyc();

        // JAL in HOLD with id_ready high: held instruction must not be accepted
        q_req.push_back(32'h410);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 32'h400, 32'h10, 32'h0, 1'b1);
        cyc(); cyc();

        // JALR rs1=0x1001 imm=4 -> 0x1004
        q_req.push_back(32'h1004);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h4, 32'h1001, 1'b0);
        cyc(); cyc();
        chk("jalr_pc", if_pc, 32'h1004);

        // JALR rs1=0x1002 imm=4: aligned to 0x1004, or trap with the macro
`ifdef PC_MISALIGN_TRAP_EN
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h4, 32'h1002, 1'b0);
        chk("trap_set", {31'h0, trap}, 32'h1);
        chk("trap_valid", {31'h0, if_valid}, 32'h0);
        chk("trap_req", {31'h0, imem_req}, 32'h0);
        repeat (5) cyc();
        chk("trap_held", {31'h0, trap}, 32'h1);
        chk("trap_no_req", {31'h0, imem_req}, 32'h0);
        q_req.push_back(RPC);
        rst_n = 1'b0;
        #1;
        chk("trap_cleared", {31'h0, trap}, 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc(); cyc(); cyc();
        hp = RPC;
`else
        q_req.push_back(32'h1004);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h4, 32'h1002, 1'b0);
        cyc(); cyc();
        hp = 32'h1004;
`endif
        chk("pre_drop_pc", if_pc, hp);

        // Delayed ack (3 wait cycles) with redirect to 0x300 in first wait cycle
        ack_delay = 3;
        q_acc.push_back(hp); q_req.push_back(hp + 32'h4); q_req.push_back(32'h300);
        id_ready = 1'b1;
        cyc();
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 32'h2F0, 32'h10, 32'h0, 1'b0);
        ack_delay = 0;
        chk("drop_no_valid_w2", {31'h0, if_valid}, 32'h0);
        cyc();
        chk("drop_no_valid_w3", {31'h0, if_valid}, 32'h0);
        cyc();
        chk("drop_no_valid_ack", {31'h0, if_valid}, 32'h0);
        cyc();
        chk("drop_no_valid_req", {31'h0, if_valid}, 32'h0);
        chk("drop_retarget", imem_addr, 32'h300);
        cyc();
        chk("drop_then_valid", {31'h0, if_valid}, 32'h1);
        chk("drop_then_pc", if_pc, 32'h300);

        // Redirect in REQ with same-cycle ack
        q_acc.push_back(32'h300); q_req.push_back(32'h304); q_req.push_back(32'h500);
        id_ready = 1'b1;
        cyc();
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 32'h4F0, 32'h10, 32'h0, 1'b0);
        chk("reqack_redir_valid", {31'h0, if_valid}, 32'h0);
        chk("reqack_redir_req", {31'h0, imem_req}, 32'h1);
        cyc(); cyc();
        chk("reqack_redir_pc", if_pc, 32'h500);

        // Target wraps past 0xFFFF_FFFC to 0
        q_req.push_back(32'h0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h10, 32'h0, 1'b0);
        cyc(); cyc();
        chk("wrap_pc", if_pc, 32'h0);

        // Reset asserted while a request is waiting for its ack
        ack_delay = 5;
        q_acc.push_back(32'h0); q_req.push_back(32'h4); q_req.push_back(RPC);
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        ack_delay = 0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        chk("restart_valid", {31'h0, if_valid}, 32'h1);
        chk("restart_pc", if_pc, RPC);
        chk("restart_instr", if_instr, mem_word(RPC));
        repeat (3) cyc();

        chk("req_queue_drained", q_req.size(), 32'h0);
        chk("acc_queue_drained", q_acc.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_riscv.md
# fetch_pc_riscv

Instruction-fetch and program-counter stage for the RISC-V core. Holds the PC, fetches instructions over a request/acknowledge instruction-memory port, and hands them to decode through a valid/ready handshake. Consumes the branch `Flag` produced by the ALU in execute, together with the resolved jump/branch operands, to redirect the PC and flush stale fetches.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value fetched first after reset.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `imem_req_o` output, 1 bit: fetch request to instruction memory.
- `imem_addr_o` output, 32 bits: fetch address; word-aligned.
- `imem_ack_i` input, 1 bit: memory returns data this cycle. Asserting it in the same cycle as the request is legal.
- `imem_rdata_i` input, 32 bits: instruction word; valid only when `imem_ack_i` is high.
- `if_valid_o` output, 1 bit: instruction available to decode.
- `if_instr_o` output, 32 bits: fetched instruction.
- `if_pc_o` output, 32 bits: PC of `if_instr_o`.
- `id_ready_i` input, 1 bit: decode accepts the instruction this cycle.
- `ex_valid_i` input, 1 bit: execute presents a resolved control-flow instruction; single-cycle pulse.
- `ex_branch_i`, `ex_jal_i`, `ex_jalr_i` inputs, 1 bit each: instruction class. At most one is high.
- `ex_flag_i` input, 1 bit: ALU `Flag` (branch condition true).
- `ex_pc_i`, `ex_imm_i`, `ex_rs1_i` inputs, 32 bits each: PC, sign-extended immediate, and rs1 value of the execute instruction.
- `trap_o` output, 1 bit: misaligned-target trap. Present only with `PC_MISALIGN_TRAP_EN`.

## Operation
- Redirect is taken when `ex_valid_i` is high and one of the following holds:
  - `ex_jal_i`, or
  - `ex_jalr_i`, or
  - `ex_branch_i && ex_flag_i`.
- A branch that is not taken (`ex_flag_i` = 0) does not redirect.
- Target calculation:
  - branch or JAL: `ex_pc_i + ex_imm_i`.
  - JALR: `(ex_rs1_i + ex_imm_i) & ~32'h1`.
  - Additions are 32-bit modulo; wrap past `32'hFFFF_FFFC` to 0 is legal.
- FSM states:
  - IDLE: reset state. Next state is REQ with `pc = RESET_PC`.
  - REQ: `imem_req_o` = 1, `imem_addr_o` = pc. On ack: capture the instruction and pc into the output registers, set `pc = pc + 4`, go to HOLD.
  - HOLD: `if_valid_o` = 1. On `id_ready_i`: go to REQ.
  - DROP: an outstanding request is being discarded. Keep `imem_req_o`/`imem_addr_o` stable until ack, drop the data, then go to REQ with the saved target.
  - TRAP: only with the macro (see Configuration).
- Request rule: once raised, `imem_req_o` and `imem_addr_o` hold until `imem_ack_i`. A request is never withdrawn.
- Redirect priority is above every other event:
  - In REQ with ack in the same cycle: discard the data, `pc = target`, stay in REQ.
  - In REQ without ack: save the target, go to DROP.
  - In HOLD, including when `id_ready_i` is high in the same cycle: clear `if_valid_o`, `pc = target`, go to REQ. The held instruction is not accepted.
  - In DROP: overwrite the saved target with the newest one.
- `if_instr_o` and `if_pc_o` stay stable while `if_valid_o` is high and `id_ready_i` is low.

## Timing
- Reset values:
  - `imem_req_o` = 0, `imem_addr_o` = `RESET_PC`.
  - `if_valid_o` = 0, `if_instr_o` = `32'h0000_0013` (NOP), `if_pc_o` = `RESET_PC`.
  - `trap_o` = 0.
- First `imem_req_o` is asserted in the second cycle after `rst_n` deasserts.
- With zero-wait memory (ack in the request cycle), `if_valid_o` rises in the next cycle.
- Throughput is 1 instruction per 2 cycles minimum; each memory wait cycle adds 1.
- Redirect to first request at the target:
  - 1 cycle from REQ-with-ack or from HOLD.
  - From REQ without ack: wait for the ack, then 1 cycle.
- Reset asserted mid-operation forces IDLE immediately; the outstanding request is abandoned.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined:
  - A redirect target with `target[1] = 1` takes no fetch.
  - `trap_o` is asserted and held; the FSM enters TRAP with `if_valid_o = 0`, `imem_req_o = 0`.
  - The FSM stays in TRAP until reset.
  - If a request is outstanding, the FSM first passes through DROP.
- Not defined: `target[1:0]` is forced to 0, there is no TRAP state, and there is no `trap_o` port.

## Structure
- Shared package `riscv_pkg` holds:
  - the ALU opcode constants;
  - the fetch FSM state encoding;
  - `NOP_INSTR` = `32'h0000_0013`;
  - the default reset PC.
- One sub-module, `pc_target_riscv`: combinational target/redirect computation (taken decision, adder, JALR LSB clear, misalignment flag).

## Test plan
- Reset with `RESET_PC = 32'h100` and zero-wait memory, `id_ready_i = 1` → addresses `0x100`, `0x104`, `0x108` on alternate cycles; `if_pc_o` follows them.
- BEQ at `ex_pc = 0x200`, `imm = 0x40`, `ex_flag = 1`, while in HOLD → `if_valid_o` drops and the next request is at `0x240`. Same stimulus with `ex_flag = 0` → no redirect.
- JALR with `rs1 = 0x1001`, `imm = 0x4` → request at `0x1004`. Without the macro, `rs1 = 0x1002` gives `0x1004`; with the macro, it gives `trap_o = 1`, and the bench checks that no further requests are issued.
- Memory ack delayed 3 cycles with a redirect to `0x300` in the first wait cycle → address stable until ack, data discarded (no `if_valid_o`), then request at `0x300`.
- `id_ready_i = 0` for 5 cycles in HOLD → `if_instr_o`/`if_pc_o` stable and no request; after `id_ready_i = 1`, the next request is at pc + 4.
- `rst_n` pulsed low mid-wait → outputs return to reset values in the same cycle, and fetch restarts at `RESET_PC`.
